// File: rtl/vga_cursor_overlay.sv
// Hardware mouse cursor: overlays a 16x16, 2-bit-per-pixel bitmap on the dot-clock RGB/sync/DE stream with fixed 2-cycle latency.
// Optional build macro VGA_CURSOR_BLINK_EN adds blink_i and a 32-frame blink cycle.
module vga_cursor_overlay #(
    parameter int XBITS = 11,
    parameter int YBITS = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
`ifdef VGA_CURSOR_BLINK_EN
    input  logic             blink_i,
`endif
    input  logic [XBITS-1:0] pos_x_i,
    input  logic [YBITS-1:0] pos_y_i,
    input  logic [23:0]      col0_i,
    input  logic [23:0]      col1_i,
    input  logic             bmp_we_i,
    input  logic [3:0]       bmp_adr_i,
    input  logic [31:0]      bmp_dat_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             de_i,
    input  logic [7:0]       r_i,
    input  logic [7:0]       g_i,
    input  logic [7:0]       b_i,
    output logic             hsync_o,
    output logic             vsync_o,
    output logic             de_o,
    output logic [7:0]       r_o,
    output logic [7:0]       g_o,
    output logic [7:0]       b_o
);

    logic [31:0]      bmp_mem_q [16];

    logic             vsync_q;
    logic             de_prev_q;
    logic             en_q;
    logic [XBITS-1:0] pos_x_q;
    logic [YBITS-1:0] pos_y_q;
    logic [XBITS-1:0] x_cnt_q, x_cnt_d;
    logic [YBITS-1:0] y_cnt_q, y_cnt_d;

    logic             s1_hit_q, s1_hit_d;
    logic [3:0]       s1_dx_q;
    logic [3:0]       s1_dy_q;
    logic [23:0]      s1_rgb_q;
    logic             s1_hs_q, s1_vs_q, s1_de_q;

    logic             hsync_q, vsync_q2, de_q;
    logic [23:0]      rgb_q, rgb_d;

    logic             frame_start_s;
    logic             de_fall_s;
    logic [XBITS-1:0] dx_full_s;
    logic [YBITS-1:0] dy_full_s;
    logic             in_x_s, in_y_s;
    logic             blink_ok_s;
    logic [31:0]      row_s;
    logic [1:0]       code_s;

    // Bitmap storage: plain synchronous write, deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (bmp_we_i) begin
            bmp_mem_q[bmp_adr_i] <= bmp_dat_i;
        end
    end

    // Frame-start/line-end detection, saturating counters and hit window.
    always_comb begin
        frame_start_s = vsync_i & ~vsync_q;
        de_fall_s     = de_prev_q & ~de_i;

        x_cnt_d = {XBITS{1'b0}};
        if (de_i) begin
            if (x_cnt_q == {XBITS{1'b1}}) begin
                x_cnt_d = x_cnt_q;
            end else begin
                x_cnt_d = x_cnt_q + {{(XBITS-1){1'b0}}, 1'b1};
            end
        end else begin
            x_cnt_d = {XBITS{1'b0}};
        end

        y_cnt_d = y_cnt_q;
        if (frame_start_s) begin
            y_cnt_d = {YBITS{1'b0}};
        end else if (de_fall_s && (y_cnt_q != {YBITS{1'b1}})) begin
            y_cnt_d = y_cnt_q + {{(YBITS-1){1'b0}}, 1'b1};
        end else begin
            y_cnt_d = y_cnt_q;
        end

        // Unsigned difference; upper bits zero means within 16 of the origin, so no wrap.
        dx_full_s = x_cnt_q - pos_x_q;
        dy_full_s = y_cnt_q - pos_y_q;
        in_x_s    = (x_cnt_q >= pos_x_q) && (dx_full_s[XBITS-1:4] == {(XBITS-4){1'b0}});
        in_y_s    = (y_cnt_q >= pos_y_q) && (dy_full_s[YBITS-1:4] == {(YBITS-4){1'b0}});
        s1_hit_d  = en_q & de_i & in_x_s & in_y_s & blink_ok_s;
    end

    // Shadowed configuration and pixel/line counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vsync_q   <= 1'b0;
            de_prev_q <= 1'b0;
            en_q      <= 1'b0;
            pos_x_q   <= {XBITS{1'b0}};
            pos_y_q   <= {YBITS{1'b0}};
            x_cnt_q   <= {XBITS{1'b0}};
            y_cnt_q   <= {YBITS{1'b0}};
        end else begin
            vsync_q   <= vsync_i;
            de_prev_q <= de_i;
            x_cnt_q   <= x_cnt_d;
            y_cnt_q   <= y_cnt_d;
            if (frame_start_s) begin
                en_q    <= en_i;
                pos_x_q <= pos_x_i;
                pos_y_q <= pos_y_i;
            end
        end
    end

`ifdef VGA_CURSOR_BLINK_EN
    logic       blink_q;
    logic       vis_q;
    logic [4:0] frame_cnt_q;

    // Blink state: visibility follows the frame counter MSB, updated once per frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blink_q     <= 1'b0;
            vis_q       <= 1'b0;
            frame_cnt_q <= 5'd0;
        end else if (frame_start_s) begin
            blink_q     <= blink_i;
            vis_q       <= frame_cnt_q[4];
            frame_cnt_q <= frame_cnt_q + 5'd1;
        end
    end

    assign blink_ok_s = ~blink_q | vis_q;
`else
    assign blink_ok_s = 1'b1;
`endif

    // Stage 1: hit decision, bitmap coordinates and delayed stream.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_hit_q <= 1'b0;
            s1_dx_q  <= 4'd0;
            s1_dy_q  <= 4'd0;
            s1_rgb_q <= 24'd0;
            s1_hs_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
            s1_de_q  <= 1'b0;
        end else begin
            s1_hit_q <= s1_hit_d;
            s1_dx_q  <= dx_full_s[3:0];
            s1_dy_q  <= dy_full_s[3:0];
            s1_rgb_q <= {r_i, g_i, b_i};
            s1_hs_q  <= hsync_i;
            s1_vs_q  <= vsync_i;
            s1_de_q  <= de_i;
        end
    end

    // Stage 2 colour select; a same-cycle bitmap write is not yet visible here.
    always_comb begin
        row_s  = bmp_mem_q[s1_dy_q];
        code_s = row_s[{s1_dx_q, 1'b0} +: 2];
        rgb_d  = s1_rgb_q;
        if (s1_hit_q) begin
            case (code_s)
                2'b00:   rgb_d = s1_rgb_q;
                2'b01:   rgb_d = col0_i;
                2'b10:   rgb_d = col1_i;
                2'b11:   rgb_d = ~s1_rgb_q;
                default: rgb_d = s1_rgb_q;
            endcase
        end else begin
            rgb_d = s1_rgb_q;
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hsync_q  <= 1'b0;
            vsync_q2 <= 1'b0;
            de_q     <= 1'b0;
            rgb_q    <= 24'd0;
        end else begin
            hsync_q  <= s1_hs_q;
            vsync_q2 <= s1_vs_q;
            de_q     <= s1_de_q;
            rgb_q    <= rgb_d;
        end
    end

    assign hsync_o = hsync_q;
    assign vsync_o = vsync_q2;
    assign de_o    = de_q;
    assign r_o     = rgb_q[23:16];
    assign g_o     = rgb_q[15:8];
    assign b_o     = rgb_q[7:0];

endmodule

// File: tb/tb_vga_cursor_overlay.sv
// Randomised stream bench for vga_cursor_overlay: a frame-level reference model predicts every output cycle.
module tb_vga_cursor_overlay;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [10:0] pos_x_i;
    logic [10:0] pos_y_i;
    logic [23:0] col0_i, col1_i;
    logic        bmp_we_i;
    logic [3:0]  bmp_adr_i;
    logic [31:0] bmp_dat_i;
    logic        hsync_i, vsync_i, de_i;
    logic [7:0]  r_i, g_i, b_i;
    logic        hsync_o, vsync_o, de_o;
    logic [7:0]  r_o, g_o, b_o;

    vga_cursor_overlay #(.XBITS(11), .YBITS(11)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
        .pos_x_i(pos_x_i), .pos_y_i(pos_y_i),
        .col0_i(col0_i), .col1_i(col1_i),
        .bmp_we_i(bmp_we_i), .bmp_adr_i(bmp_adr_i), .bmp_dat_i(bmp_dat_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i),
        .r_i(r_i), .g_i(g_i), .b_i(b_i),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
        .r_o(r_o), .g_o(g_o), .b_o(b_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
        logic [15:0] x;
        logic [15:0] y;
    } exp_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    exp_t        e1, e2;
    logic [31:0] bmp_m [16];
    int          m_en, m_px, m_py;
    logic        vs_prev;
    logic        rst_req;
    logic        fixed_en;
    logic [23:0] fixed_rgb;
    int          pr_n;
    int          pr_x [8];
    int          pr_y [8];
    logic [23:0] pr_v [8];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic add_probe(input int x, input int y, input logic [23:0] v);
        pr_x[pr_n] = x;
        pr_y[pr_n] = y;
        pr_v[pr_n] = v;
        pr_n++;
    endtask

    // One dot-clock cycle: check the output due now, drive new inputs, predict their output.
    task automatic cycle(input logic hs, input logic vs, input logic de, input int x, input int y);
        logic [23:0] rgb, outc;
        int          code;
        @(negedge clk_i);
        check_eq(rst_i ? "reset" : "stream",
                 {5'd0, hsync_o, vsync_o, de_o, r_o, g_o, b_o},
                 {5'd0, e2.hs, e2.vs, e2.de, e2.rgb});
        for (int i = 0; i < pr_n; i++) begin
            if (e2.de && (int'(e2.x) == pr_x[i]) && (int'(e2.y) == pr_y[i]))
                check_eq("probe", {8'd0, r_o, g_o, b_o}, {8'd0, pr_v[i]});
        end
        e2 = e1;
        rst_i   = rst_req;
        hsync_i = hs;
        vsync_i = vs;
        de_i    = de;
        rgb     = fixed_en ? fixed_rgb : 24'($urandom);
        {r_i, g_i, b_i} = rgb;
        if (rst_i) begin
            e1 = '0;
            e2 = '0;
            vs_prev = 1'b0;
            m_en = 0; m_px = 0; m_py = 0;
        end else begin
            outc = rgb;
            if (m_en != 0 && de && x >= m_px && x < m_px + 16 && y >= m_py && y < m_py + 16) begin
                code = int'(bmp_m[y - m_py][2*(x - m_px) +: 2]);
                if (code == 1)      outc = col0_i;
                else if (code == 2) outc = col1_i;
                else if (code == 3) outc = ~rgb;
            end
            e1 = {hs, vs, de, outc, 16'(x), 16'(y)};
            if (vs && !vs_prev) begin
                m_en = int'(en_i);
                m_px = int'(pos_x_i);
                m_py = int'(pos_y_i);
            end
            vs_prev = vs;
        end
    endtask

    task automatic bmp_write(input int adr, input logic [31:0] dat);
        bmp_we_i  = 1'b1;
        bmp_adr_i = 4'(adr);
        bmp_dat_i = dat;
        bmp_m[adr] = dat;
        cycle(1'b0, 1'b0, 1'b0, 0, 0);
        bmp_we_i = 1'b0;
    endtask

    task automatic line(input int w, input int y, input int rst_at);
        for (int x = 0; x < w; x++) begin
            if (x == rst_at)     rst_req = 1'b1;
            if (x == rst_at + 3) rst_req = 1'b0;
            cycle(1'b0, 1'b0, 1'b1, x, y);
        end
        for (int i = 0; i < 6; i++) cycle((i == 2) || (i == 3), 1'b0, 1'b0, 0, y);
    endtask

    task automatic vsync_seq();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic frame(input int w, input int h, input int chg_line, input int chg_px);
        vsync_seq();
        for (int y = 0; y < h; y++) begin
            if (y == chg_line) pos_x_i = 11'(chg_px);
            line(w, y, -1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; rst_req = 1'b1;
        en_i = 1'b0; pos_x_i = 11'd0; pos_y_i = 11'd0;
        col0_i = 24'd0; col1_i = 24'd0;
        bmp_we_i = 1'b0; bmp_adr_i = 4'd0; bmp_dat_i = 32'd0;
        hsync_i = 1'b0; vsync_i = 1'b0; de_i = 1'b0;
        r_i = 8'd0; g_i = 8'd0; b_i = 8'd0;
        e1 = '0; e2 = '0; vs_prev = 1'b0;
        m_en = 0; m_px = 0; m_py = 0;
        fixed_en = 1'b0; fixed_rgb = 24'd0; pr_n = 0;
        for (int i = 0; i < 16; i++) bmp_m[i] = 32'd0;

        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0);
        rst_req = 1'b0;

        // Disabled cursor with a random bitmap: pure 2-cycle pass-through.
        for (int i = 0; i < 16; i++) bmp_write(i, $urandom);
        frame(640, 8, -1, 0);

        // Solid code-01 cursor at (100,50).
        for (int i = 0; i < 16; i++) bmp_write(i, 32'h5555_5555);
        col0_i = 24'hFF0000; col1_i = 24'h00FF00;
        pos_x_i = 11'd100; pos_y_i = 11'd50; en_i = 1'b1;
        fixed_en = 1'b1; fixed_rgb = 24'h0000FF;
        pr_n = 0;
        add_probe(100, 50, 24'hFF0000); add_probe(115, 65, 24'hFF0000);
        add_probe(99, 50, 24'h0000FF);  add_probe(116, 50, 24'h0000FF);
        add_probe(100, 66, 24'h0000FF); add_probe(100, 49, 24'h0000FF);
        frame(160, 70, -1, 0);

        // Invert and col1 codes.
        bmp_write(0, 32'h0000_0003);
        bmp_write(1, 32'h0000_0002);
        pos_x_i = 11'd4; pos_y_i = 11'd2; fixed_rgb = 24'h123456;
        pr_n = 0;
        add_probe(4, 2, 24'hEDCBA9); add_probe(4, 3, 24'h00FF00); add_probe(5, 2, 24'h123456);
        frame(40, 8, -1, 0);

        // Right-edge clipping with no wrap onto the next line.
        for (int i = 0; i < 16; i++) bmp_write(i, 32'h5555_5555);
        pos_x_i = 11'd632; pos_y_i = 11'd2; fixed_rgb = 24'h0000FF;
        pr_n = 0;
        add_probe(632, 2, 24'hFF0000); add_probe(639, 17, 24'hFF0000);
        add_probe(631, 2, 24'h0000FF); add_probe(0, 2, 24'h0000FF);
        add_probe(7, 3, 24'h0000FF);   add_probe(0, 17, 24'h0000FF);
        frame(640, 20, -1, 0);

        // Mid-frame position change only takes effect at the next frame start.
        pos_x_i = 11'd100; pos_y_i = 11'd4;
        pr_n = 0;
        add_probe(100, 4, 24'hFF0000); add_probe(300, 4, 24'h0000FF);
        frame(320, 8, 1, 300);
        pr_n = 0;
        add_probe(300, 4, 24'hFF0000); add_probe(100, 4, 24'h0000FF);
        frame(320, 8, -1, 0);

        // Reset mid-line: cursor stays hidden until the next vsync rising edge.
        pos_x_i = 11'd2; pos_y_i = 11'd1; en_i = 1'b1;
        fixed_en = 1'b0;
        pr_n = 0;
        vsync_seq();
        line(20, 0, 5);
        fixed_en = 1'b1;
        add_probe(3, 1, 24'h0000FF);
        for (int y = 1; y < 5; y++) line(20, y, -1);
        pr_n = 0;
        add_probe(3, 1, 24'hFF0000); add_probe(2, 2, 24'hFF0000); add_probe(1, 1, 24'h0000FF);
        frame(20, 6, -1, 0);

        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
